// File: rtl/fractal_pixel_writer_if.sv
// Pixel-writer bus: producer-side pixel handshake, frame control,
// framebuffer write port and status outputs, grouped for the writer block.
interface fractal_pixel_writer_if;
    logic               pix_valid;
    logic               pix_ready;
    logic signed [15:0] x_draw;
    logic signed [15:0] y_draw;
    logic [7:0]         intensity;
    logic               calculating;
    logic               clear_req;
    logic               mem_we;
    logic [18:0]        mem_addr;
    logic [7:0]         mem_data;
    logic               mem_ready;
    logic               busy;
    logic               frame_done;
    logic [15:0]        drop_count;

    modport master (
        output pix_valid, x_draw, y_draw, intensity, calculating, clear_req, mem_ready,
        input  pix_ready, mem_we, mem_addr, mem_data, busy, frame_done, drop_count
    );

    modport slave (
        input  pix_valid, x_draw, y_draw, intensity, calculating, clear_req, mem_ready,
        output pix_ready, mem_we, mem_addr, mem_data, busy, frame_done, drop_count
    );
endinterface

// File: rtl/fractal_pixel_writer.sv
// Fractal pixel writer: range-checks incoming pixels, converts escape
// intensity to gray, queues {address, gray} and streams them to the
// framebuffer. Also sweeps the frame to zero on request and flags frame end.
module fractal_pixel_writer #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    fractal_pixel_writer_if.slave bus
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int NPIX = IMG_W * IMG_H;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t             state_q, state_d;
    logic [26:0]        fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]        fifo_cnt_q, fifo_cnt_d;
    logic [AW+1:0]      occ;
    logic               mem_we_q, mem_we_d;
    logic [18:0]        mem_addr_q, mem_addr_d;
    logic [7:0]         mem_data_q, mem_data_d;
    logic [15:0]        drop_q, drop_d;
    logic               clr_pend_q, clr_pend_d;
    logic               done_pend_q, done_pend_d;
    logic               calc_q;
    logic               frame_done_q, frame_done_d;
    logic [19:0]        clr_cnt_q, clr_cnt_d;

    logic signed [31:0] x_s, y_s;
    logic               in_range, accept, push, pop, out_free, fifo_empty, done_fire, pix_ready;
    logic [7:0]         int_c, gray;
    logic [18:0]        addr_c;

    // Pixel conversion: bounds check, intensity clamp, 5/2 gray scaling, linear address.
    assign x_s      = {{16{bus.x_draw[15]}}, bus.x_draw};
    assign y_s      = {{16{bus.y_draw[15]}}, bus.y_draw};
    assign in_range = (x_s >= 0) && (x_s < IMG_W) && (y_s >= 0) && (y_s < IMG_H);
    assign int_c    = (bus.intensity > 8'd100) ? 8'd100 : bus.intensity;
    // 2*c + c/2 equals floor(5*c/2) exactly and stays within 8 bits for c <= 100.
    assign gray     = {int_c[6:0], 1'b0} + {1'b0, int_c[7:1]};
    assign addr_c   = 19'(bus.y_draw) * 19'(IMG_W) + 19'(bus.x_draw);

    // Occupancy counts the presented write as well, so the queue plus the
    // output register together hold at most FIFO_DEPTH pixels.
    assign occ        = {1'b0, fifo_cnt_q} + {{(AW + 1){1'b0}}, mem_we_q};
    assign fifo_empty = (fifo_cnt_q == '0);
    assign pix_ready  = RESET && (state_q == S_IDLE) && (occ < (AW + 2)'(FIFO_DEPTH));
    assign accept     = bus.pix_valid && pix_ready;
    assign push       = accept && in_range;
    assign out_free   = !mem_we_q || bus.mem_ready;
    assign pop        = (state_q == S_IDLE) && out_free && !fifo_empty;
    assign done_fire  = done_pend_q && fifo_empty && !mem_we_q && (state_q == S_IDLE);

    assign bus.pix_ready  = pix_ready;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_data   = mem_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.drop_count = drop_q;
    assign bus.busy       = (state_q == S_CLEAR) || !fifo_empty || mem_we_q || clr_pend_q || done_pend_q;

    // Queue storage: written on push only, contents need no reset.
    always_ff @(posedge CLK) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {addr_c, gray};
    end

    // Next-state: queue pointers, write port, clear sweep, drop and frame-end flags.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_cnt_d   = fifo_cnt_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        drop_d       = drop_q;
        clr_pend_d   = clr_pend_q;
        clr_cnt_d    = clr_cnt_q;
        frame_done_d = done_fire;
        done_pend_d  = done_pend_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + (AW + 1)'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - (AW + 1)'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        if (accept && !in_range && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;

        if (bus.clear_req && (state_q != S_CLEAR)) clr_pend_d = 1'b1;

        if (calc_q && !bus.calculating) done_pend_d = 1'b1;
        else if (done_fire)             done_pend_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = fifo_mem_q[rd_ptr_q][26:8];
                    mem_data_d = fifo_mem_q[rd_ptr_q][7:0];
                end else if (out_free) begin
                    mem_we_d = 1'b0;
                end
                if (clr_pend_q && fifo_empty && !mem_we_q && !bus.calculating) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            S_CLEAR: begin
                if (out_free) begin
                    if (clr_cnt_q < 20'(NPIX)) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = clr_cnt_q[18:0];
                        mem_data_d = 8'd0;
                        clr_cnt_d  = clr_cnt_q + 20'd1;
                    end else begin
                        mem_we_d   = 1'b0;
                        state_d    = S_IDLE;
                        clr_pend_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            drop_q       <= '0;
            clr_pend_q   <= 1'b0;
            done_pend_q  <= 1'b0;
            calc_q       <= 1'b0;
            frame_done_q <= 1'b0;
            clr_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            drop_q       <= drop_d;
            clr_pend_q   <= clr_pend_d;
            done_pend_q  <= done_pend_d;
            calc_q       <= bus.calculating;
            frame_done_q <= frame_done_d;
            clr_cnt_q    <= clr_cnt_d;
        end
    end
endmodule

// File: tb/tb_fractal_pixel_writer.sv
// Directed bench for fractal_pixel_writer: a 640x480 instance for the pixel
// path and a 4x2 instance for the frame-clear sweep.
module tb_fractal_pixel_writer;
    logic CLK = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    fractal_pixel_writer_if b ();
    fractal_pixel_writer_if s ();

    fractal_pixel_writer #(.IMG_W(640), .IMG_H(480), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RESET(RESET), .bus(b.slave)
    );
    fractal_pixel_writer #(.IMG_W(4), .IMG_H(2), .FIFO_DEPTH(4)) dut_s (
        .CLK(CLK), .RESET(RESET), .bus(s.slave)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [26:0] wq[$];
    int          wc[$];
    int          fd_cnt = 0;
    int          fd_cyc = 0;
    logic [26:0] sq[$];
    int          s_rdy_err = 0;
    int          s_fd = 0;

    // Record accepted writes and frame_done pulses of the main instance.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (b.mem_we && b.mem_ready) begin
            wq.push_back({b.mem_addr, b.mem_data});
            wc.push_back(cyc);
        end
        if (b.frame_done) begin
            fd_cnt <= fd_cnt + 1;
            fd_cyc <= cyc;
        end
    end

    // Record writes of the small instance and anything illegal during its sweep.
    always @(posedge CLK) begin
        if (s.mem_we && s.mem_ready) sq.push_back({s.mem_addr, s.mem_data});
        if (s.mem_we && s.pix_ready) s_rdy_err <= s_rdy_err + 1;
        if (s.frame_done) s_fd <= s_fd + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input int x, input int y, input int in);
        logic r;
        bit   ok;
        ok = 0;
        b.x_draw = 16'(x);
        b.y_draw = 16'(y);
        b.intensity = 8'(in);
        b.pix_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            r = b.pix_ready;
            step();
            if (r) ok = 1;
        end
        b.pix_valid = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_writes(input int n);
        for (int i = 0; i < 200 && wq.size() < n; i++) step();
    endtask

    initial begin
        int   base;
        int   k;
        logic r;
        logic v;

        b.pix_valid = 0; b.x_draw = 0; b.y_draw = 0; b.intensity = 0;
        b.calculating = 0; b.clear_req = 0; b.mem_ready = 0;
        s.pix_valid = 0; s.x_draw = 0; s.y_draw = 0; s.intensity = 0;
        s.calculating = 0; s.clear_req = 0; s.mem_ready = 1;

        // Reset state
        step(); step();
        chk("rst_we", b.mem_we, 0);
        chk("rst_addr", b.mem_addr, 0);
        chk("rst_data", b.mem_data, 0);
        chk("rst_busy", b.busy, 0);
        chk("rst_fd", b.frame_done, 0);
        chk("rst_drop", b.drop_count, 0);
        chk("rst_ready_low", b.pix_ready, 0);
        RESET = 1'b1;
        #1;
        chk("rst_ready_high", b.pix_ready, 1);
        step();

        // Single pixel: (3,2) int 100 -> addr 1283, data 250, one cycle after accept
        base = wq.size();
        b.mem_ready = 1;
        b.x_draw = 16'd3; b.y_draw = 16'd2; b.intensity = 8'd100; b.pix_valid = 1;
        chk("sp_ready", b.pix_ready, 1);
        step();
        b.pix_valid = 0;
        chk("sp_we_accept_cycle", b.mem_we, 0);
        step();
        chk("sp_we", b.mem_we, 1);
        chk("sp_addr", b.mem_addr, 1283);
        chk("sp_data", b.mem_data, 250);
        step();
        chk("sp_nwrites", wq.size() - base, 1);
        chk("sp_we_after", b.mem_we, 0);

        // Backpressure: 6 pixels offered while memory stalls
        base = wq.size();
        b.mem_ready = 0;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            v = (k < 6);
            b.pix_valid = v; b.x_draw = 16'(10 + k); b.y_draw = 16'd5; b.intensity = 8'(10 * k);
            r = b.pix_ready;
            step();
            if (v && r) k++;
        end
        chk("bp_accepts", k, 4);
        chk("bp_ready_low", b.pix_ready, 0);
        chk("bp_we", b.mem_we, 1);
        chk("bp_addr", b.mem_addr, 3210);
        chk("bp_data", b.mem_data, 0);
        b.pix_valid = 0;
        step();
        chk("bp_addr_hold", b.mem_addr, 3210);
        chk("bp_we_hold", b.mem_we, 1);
        b.mem_ready = 1;
        for (int c = 0; c < 20; c++) begin
            v = (k < 6);
            b.pix_valid = v; b.x_draw = 16'(10 + k); b.y_draw = 16'd5; b.intensity = 8'(10 * k);
            r = b.pix_ready;
            step();
            if (v && r) k++;
        end
        b.pix_valid = 0;
        chk("bp_all_accepted", k, 6);
        wait_writes(base + 6);
        chk("bp_nwrites", wq.size() - base, 6);
        if (wq.size() >= base + 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("bp_order_addr", wq[base + i][26:8], 3210 + i);
                chk("bp_order_data", wq[base + i][7:0], 25 * i);
            end
            chk("bp_back_to_back", wc[base + 5] - wc[base], 5);
        end

        // Range and clamp
        base = wq.size();
        send(-1, 0, 50);
        send(640, 0, 50);
        send(0, 480, 50);
        step(); step();
        chk("rng_drop", b.drop_count, 3);
        chk("rng_no_write", wq.size() - base, 0);
        send(0, 0, 200);
        send(1, 0, 7);
        wait_writes(base + 2);
        chk("clamp_nwrites", wq.size() - base, 2);
        if (wq.size() >= base + 2) begin
            chk("clamp_addr", wq[base][26:8], 0);
            chk("clamp_data", wq[base][7:0], 250);
            chk("int7_addr", wq[base + 1][26:8], 1);
            chk("int7_data", wq[base + 1][7:0], 17);
        end

        // Clear sweep on the 4x2 instance
        s.clear_req = 1;
        step();
        s.clear_req = 0;
        for (int i = 0; i < 50 && sq.size() < 8; i++) step();
        step(); step(); step();
        chk("clr_nwrites", sq.size(), 8);
        if (sq.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("clr_addr", sq[i][26:8], i);
                chk("clr_data", sq[i][7:0], 0);
            end
        end
        chk("clr_ready_during", s_rdy_err, 0);
        chk("clr_no_fd", s_fd, 0);
        chk("clr_busy_end", s.busy, 0);
        chk("clr_ready_end", s.pix_ready, 1);

        // Frame done with two entries queued behind a stalled memory
        base = wq.size();
        k = fd_cnt;
        b.calculating = 1;
        b.mem_ready = 0;
        step();
        send(1, 1, 50);
        send(2, 1, 50);
        b.calculating = 0;
        for (int i = 0; i < 5; i++) step();
        chk("fd_none_stalled", fd_cnt - k, 0);
        chk("fd_busy", b.busy, 1);
        b.mem_ready = 1;
        wait_writes(base + 2);
        step(); step(); step(); step();
        chk("fd_nwrites", wq.size() - base, 2);
        chk("fd_pulses", fd_cnt - k, 1);
        if (wq.size() >= base + 2) chk("fd_after_last_write", fd_cyc > wc[base + 1], 1);
        chk("fd_busy_end", b.busy, 0);

        // Reset while a write is outstanding
        b.mem_ready = 0;
        send(5, 5, 100);
        for (int i = 0; i < 10 && !b.mem_we; i++) step();
        chk("rmw_we_pre", b.mem_we, 1);
        chk("rmw_drop_pre", b.drop_count, 3);
        RESET = 1'b0;
        step();
        chk("rmw_we", b.mem_we, 0);
        chk("rmw_drop", b.drop_count, 0);
        chk("rmw_busy", b.busy, 0);
        chk("rmw_ready_low", b.pix_ready, 0);
        RESET = 1'b1;
        #1;
        chk("rmw_ready_high", b.pix_ready, 1);
        base = wq.size();
        b.mem_ready = 1;
        for (int i = 0; i < 5; i++) step();
        chk("rmw_no_write", wq.size() - base, 0);
        chk("rmw_we_idle", b.mem_we, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fractal_pixel_writer.md
FRACTAL_PIXEL_WRITER -- requirements
Module: fractal_pixel_writer

Interface
REQ-001 SHALL have parameter IMG_W, default 640, frame width in pixels.
REQ-002 SHALL have parameter IMG_H, default 480, frame height in pixels.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, pixel buffer entries (power of 2).
REQ-004 SHALL have one clock and a synchronous, active-low reset: CLK  in  1  clock, all logic on posedge; RESET  in  1  synchronous active-low reset.
REQ-005 SHALL have ports: pix_valid  in  1  pixel offered; pix_ready  out  1  pixel accepted this edge if pix_valid.
REQ-006 SHALL have ports: x_draw  in  16  signed pixel column; y_draw  in  16  signed pixel row; intensity  in  8  escape intensity, nominal 0..100.
REQ-007 SHALL have ports: calculating  in  1  producer frame-in-progress flag; clear_req  in  1  one-cycle request to zero the frame.
REQ-008 SHALL have ports: mem_we  out  1  write request; mem_addr  out  19  framebuffer address; mem_data  out  8  gray value; mem_ready  in  1  memory accepts write.
REQ-009 SHALL have ports: busy  out  1  activity flag; frame_done  out  1  one-cycle completion pulse; drop_count  out  16  rejected-pixel count.

Function
REQ-010 SHALL complete an input handshake on each posedge where pix_valid=1 and pix_ready=1.
REQ-011 SHALL drive pix_ready=1 only when the FIFO is not full and state is not CLEAR.
REQ-012 SHALL reject an accepted pixel with x_draw<0, x_draw>=IMG_W, y_draw<0 or y_draw>=IMG_H: no FIFO push; drop_count +1, saturating at 16'hFFFF.
REQ-013 SHALL clamp intensity>100 to 100, then compute gray=(intensity*5)>>1 (range 0..250).
REQ-014 SHALL compute address=y_draw*IMG_W+x_draw, 19 bits, unsigned.
REQ-015 SHALL push {address, gray} into the FIFO for each in-range accepted pixel; simultaneous push and pop leaves the level unchanged.
REQ-016 SHALL present FIFO head on mem_addr/mem_data with mem_we=1 (registered outputs), holding all three stable until a posedge with mem_ready=1.
REQ-017 SHALL pop the head on the posedge where mem_we=1 and mem_ready=1, then present the next entry on the following cycle with no idle cycle (back-to-back).
REQ-018 SHALL provide minimum latency of one cycle: pixel accepted at edge N with FIFO empty and no pending write -> mem_we=1 after edge N+1.
REQ-019 SHALL implement states IDLE, CLEAR.
REQ-020 SHALL latch clear_req into a pending flag; IDLE->CLEAR when pending, FIFO empty, no write outstanding, calculating=0.
REQ-021 SHALL in CLEAR write gray 0 to addresses 0..IMG_W*IMG_H-1 in ascending order using the REQ-016/017 handshake, then go to IDLE and clear the pending flag.
REQ-022 SHALL ignore clear_req while already in CLEAR.
REQ-023 SHALL latch a done-pending flag on a calculating 1->0 transition, and pulse frame_done for one cycle once the FIFO is empty and no write is outstanding; done-pending then clears.
REQ-024 SHALL not pulse frame_done for the CLEAR sequence.
REQ-025 SHALL drive busy=1 when state=CLEAR, FIFO non-empty, mem_we=1, or either pending flag is set.

Reset
REQ-026 SHALL, on a posedge with RESET=0, force mem_we=0, mem_addr=0, mem_data=0, frame_done=0, busy=0, drop_count=0, state=IDLE, FIFO empty, both pending flags cleared.
REQ-027 SHALL drive pix_ready=0 while RESET=0, and pix_ready=1 on the first cycle after release.
REQ-028 SHALL abandon any in-flight write and discard FIFO contents on reset mid-operation, with no further mem_we until a new pixel arrives.

Verification
REQ-029 SHALL have scenario Single pixel: x=3,y=2,int=100, mem_ready=1 -> one write, addr=1283, data=250, one cycle after accept.
REQ-030 SHALL have scenario Backpressure: 6 pixels back-to-back, mem_ready=0 -> pix_ready falls after 4 accepts; mem_addr/data stable; with mem_ready=1, all 6 are written in order, one per cycle.
REQ-031 SHALL have scenario Range/clamp: x=-1, x=640, y=480 -> drop_count=3, no writes; int=200 at (0,0) -> data=250; int=7 -> data=17.
REQ-032 SHALL have scenario Clear: IMG_W=4,IMG_H=2, clear_req -> 8 writes of 0 to addr 0..7, pix_ready=0 throughout, no frame_done.
REQ-033 SHALL have scenario Frame done: calculating falls with 2 entries queued, mem_ready=0 for 5 cycles -> frame_done single pulse only after the second write completes.
REQ-034 SHALL have scenario Reset mid-write: RESET=0 while mem_we=1 -> mem_we=0, drop_count=0, busy=0 next cycle; pix_ready=1 after release.
